// File: rtl/debounce_pkg.sv
// Shared types and limits for the switch debouncer.
// Latency: none, since this file holds declarations only.
// Backpressure: none; no handshake is involved.
package debounce_pkg;

  // Qualification FSM. The *_CHK states count consecutive samples at the
  // candidate level before that level is accepted.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    LOW_CHK  = 2'd1,
    HIGH     = 2'd2,
    HIGH_CHK = 2'd3
  } db_state_t;

  // Smallest stable-sample count that still filters a single-sample glitch.
  localparam int DB_MIN_STABLE = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser that brings an asynchronous level into the Clock domain.
// Latency: 2 Clock edges from the sampling edge to q.
// Backpressure: none; the input is a free-running level.
//
// Ports: Clock (system clock), R_n (async active-low reset, q forced to 0),
//        d (asynchronous input), q (synchronised output).
module sync_2ff (
  input  logic Clock,
  input  logic R_n,
  input  logic d,
  output logic q
);

  logic s1;

  // s1 may go metastable. Only q is seen by the rest of the design.
  always_ff @(posedge Clock or negedge R_n) begin
    if (!R_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw switch into a clean level w, with one-cycle rise/fall pulses.
// Latency: w and the pulse appear STABLE_CYCLES+1 edges after raw is first sampled.
// Backpressure: none; consumers must sample w, rise and fall every cycle.
//
// Ports: Clock (system clock), R_n (async active-low reset),
//        raw (asynchronous bouncy input), w (debounced level),
//        rise/fall (single-cycle pulses on w 0->1 / 1->0).
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic Clock,
  input  logic R_n,
  input  logic raw,
  output logic w,
  output logic rise,
  output logic fall
);

  if (STABLE_CYCLES < DB_MIN_STABLE) begin : g_bad_stable
    $error("input_debouncer: STABLE_CYCLES must be at least DB_MIN_STABLE");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .Clock (Clock),
    .R_n   (R_n),
    .d     (raw),
    .q     (s2)
  );

  // Entering a *_CHK state counts the first candidate sample, so cnt starts at 1.
  // Acceptance happens on the sample where cnt already equals STABLE_CYCLES-1,
  // which is the STABLE_CYCLES-th consecutive sample. A reversal is checked
  // before completion, so a count can never complete on an opposite sample.
  always_ff @(posedge Clock or negedge R_n) begin
    if (!R_n) begin
      state <= LOW;
      cnt   <= '0;
      w     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW: begin
          if (s2) begin
            state <= LOW_CHK;
            cnt   <= CNT_ONE;
          end
        end
        LOW_CHK: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            w     <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= HIGH_CHK;
            cnt   <= CNT_ONE;
          end
        end
        HIGH_CHK: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            w     <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
